trace_addr_accumulator: RTL and testbench
=========================================

// Module: trace_addr_accumulator
// PURPOSE
// Upstream feeder for the cache simulation core. Consumes the signed address-delta trace
// (first word absolute, later words relative), rebuilds absolute addresses by running
// sum, and buffers them in a FIFO for the cache's one-address-per-cycle input.
// Tracks trace end and the number of addresses delivered.
// PARAMETERS
// AW     31  address/delta width in bits
// DEPTH  8   output FIFO entries, power of two, >= 2
// CW     32  width of addr_count_41
// PORTS
// clk_41         in   1    single clock, all state on rising edge
// rst_41         in   1    asynchronous, active-low reset
// restart_41     in   1    sync pulse: flush FIFO, clear counters, return to S_FIRST
// delta_41       in   AW   signed delta (absolute address if first word of a trace)
// delta_valid_41 in   1    delta_41 valid this cycle
// delta_last_41  in   1    qualifies delta_41 as last word of the trace
// delta_ready_41 out  1    block can accept a delta this cycle
// addr_41        out  AW   absolute address at FIFO head
// addr_valid_41  out  1    addr_41 valid
// addr_ready_41  in   1    cache accepts addr_41 this cycle
// addr_count_41  out  CW   addresses popped since reset/restart, saturating
// trace_done_41  out  1    last address delivered and FIFO empty
// BEHAVIOUR
// - Reset (rst_41=0, any time, async): state S_FIRST, FIFO empty, accumulator 0,
//   delta_ready_41=0 until first edge after release, addr_valid_41=0, addr_41=0,
//   addr_count_41=0, trace_done_41=0. In-flight data is discarded.
// - Accept = delta_valid_41 & delta_ready_41. Pop = addr_valid_41 & addr_ready_41.
// - delta_ready_41 = (state is S_FIRST or S_ACCUM) & (fifo_count < DEPTH). No
//   same-cycle pop bypass when full; ready is a function of registered state only.
// - addr_valid_41 = (fifo_count != 0); addr_41 = FIFO head (show-ahead), 0 when empty.
// - States:
//   S_FIRST: on accept, acc <= delta_41; push delta_41; -> S_ACCUM (or S_DRAIN if last).
//   S_ACCUM: on accept, sum = acc + delta_41 modulo 2^AW (wrap, no overflow flag);
//            acc <= sum; push sum; -> S_DRAIN if delta_last_41.
//   S_DRAIN: no accepts; -> S_DONE when FIFO empty (incl. the cycle the last entry pops).
//   S_DONE: trace_done_41=1, held until restart_41 or reset.
// - Latency: delta accepted at edge N appears on addr_41 after edge N when FIFO was
//   empty (one cycle); otherwise behind older entries, strict order preserved.
// - Simultaneous push and pop: both happen, fifo_count unchanged; allowed when full
//   is not reachable because ready already low at count==DEPTH.
// - Pop on empty never occurs (valid low). Pointers wrap modulo DEPTH.
// - addr_count_41 increments on each pop; saturates at 2^CW-1.
// - restart_41 has priority over accept/pop the same cycle: FIFO cleared, acc=0,
//   addr_count_41=0, trace_done_41=0, state S_FIRST; the accepting delta is dropped.
// - delta_last_41 ignored when delta_valid_41=0.
// TESTING
// T1 reset: hold rst_41=0 mid-stream with 3 entries queued -> all outputs 0 immediately,
//    after release first delta 500 yields addr 500, count restarts from 0.
// T2 accumulate: deltas 100,+4,-8,+1024, addr_ready_41=1 -> addresses 100,104,96,1120
//    on consecutive cycles, addr_count_41=4.
// T3 wrap: first 0x7FFFFFFF then +1, then -1 -> addresses 0x7FFFFFFF, 0, 0x7FFFFFFF.
// T4 backpressure (DEPTH=8): addr_ready_41=0, stream 10 deltas -> delta_ready_41 low
//    after 8 accepts; release ready -> all 10 addresses in order, none lost/duplicated.
// T5 end/restart: 3 deltas, last on third, ready random -> trace_done_41 rises the
//    cycle after final pop; restart_41 pulse -> done=0, count=0, next delta absolute.
// T6 restart with simultaneous accept: restart_41 & accept same cycle -> delta dropped,
//    FIFO empty next cycle, next accepted word treated as absolute.

Source files
------------

// File: rtl/trace_addr_accumulator_if.sv
// Handshake bundle between the delta-trace source and the cache-facing address stream.
// The master drives deltas and address backpressure; the slave is the accumulator.
interface trace_addr_accumulator_if #(
    parameter int AW = 31,
    parameter int CW = 32
);
    logic [AW-1:0] delta_41;
    logic          delta_valid_41;
    logic          delta_last_41;
    logic          delta_ready_41;
    logic [AW-1:0] addr_41;
    logic          addr_valid_41;
    logic          addr_ready_41;
    logic [CW-1:0] addr_count_41;
    logic          trace_done_41;

    modport master (
        output delta_41, delta_valid_41, delta_last_41, addr_ready_41,
        input  delta_ready_41, addr_41, addr_valid_41, addr_count_41, trace_done_41
    );

    modport slave (
        input  delta_41, delta_valid_41, delta_last_41, addr_ready_41,
        output delta_ready_41, addr_41, addr_valid_41, addr_count_41, trace_done_41
    );
endinterface

// File: rtl/trace_addr_accumulator.sv
// Rebuilds absolute addresses from a signed delta trace by running sum and queues them
// in a show-ahead FIFO for the cache; tracks trace end and delivered-address count.
module trace_addr_accumulator #(
    parameter int AW    = 31,
    parameter int DEPTH = 8,
    parameter int CW    = 32
) (
    input  logic                     clk_41,
    input  logic                     rst_41,
    input  logic                     restart_41,
    trace_addr_accumulator_if.slave  bus
);
    localparam int PW = $clog2(DEPTH);

    typedef enum logic [1:0] {S_FIRST, S_ACCUM, S_DRAIN, S_DONE} state_t;

    state_t        state, state_next;
    logic [AW-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [PW:0]   fifo_count;
    logic [AW-1:0] acc, push_data;
    logic [CW-1:0] addr_count;
    logic          started;
    logic          delta_ready, addr_valid, accept, pop;

    // started keeps ready low until the first edge after reset release
    assign delta_ready = started && (state == S_FIRST || state == S_ACCUM)
                         && (fifo_count < (PW+1)'(DEPTH));
    assign addr_valid  = (fifo_count != '0);
    assign accept      = bus.delta_valid_41 && delta_ready;
    assign pop         = addr_valid && bus.addr_ready_41;
    assign push_data   = (state == S_FIRST) ? bus.delta_41 : acc + bus.delta_41;

    assign bus.delta_ready_41 = delta_ready;
    assign bus.addr_valid_41  = addr_valid;
    assign bus.addr_41        = addr_valid ? mem[rd_ptr] : '0;
    assign bus.addr_count_41  = addr_count;
    assign bus.trace_done_41  = (state == S_DONE);

    always_comb begin
        state_next = state;
        case (state)
            S_FIRST: if (accept) state_next = bus.delta_last_41 ? S_DRAIN : S_ACCUM;
            S_ACCUM: if (accept && bus.delta_last_41) state_next = S_DRAIN;
            S_DRAIN: if (fifo_count == '0 || (fifo_count == (PW+1)'(1) && pop))
                         state_next = S_DONE;
            default: state_next = S_DONE;
        endcase
        if (restart_41) state_next = S_FIRST;
    end

    always_ff @(posedge clk_41 or negedge rst_41) begin
        if (!rst_41) begin
            state      <= S_FIRST;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            acc        <= '0;
            addr_count <= '0;
            started    <= 1'b0;
        end else begin
            started <= 1'b1;
            state   <= state_next;
            if (restart_41) begin
                wr_ptr     <= '0;
                rd_ptr     <= '0;
                fifo_count <= '0;
                acc        <= '0;
                addr_count <= '0;
            end else begin
                if (accept) begin
                    acc    <= push_data;
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + 1'b1;
                    if (addr_count != '1) addr_count <= addr_count + 1'b1;
                end
                case ({accept, pop})
                    2'b10:   fifo_count <= fifo_count + 1'b1;
                    2'b01:   fifo_count <= fifo_count - 1'b1;
                    default: fifo_count <= fifo_count;
                endcase
            end
        end
    end

    // Storage needs no reset: entries are only visible while fifo_count covers them
    always_ff @(posedge clk_41) begin
        if (accept && !restart_41) mem[wr_ptr] <= push_data;
    end
endmodule

// File: tb/tb_trace_addr_accumulator.sv
// Directed and randomized checks of the delta-trace accumulator against a queue-based
// model of the expected address stream, done flag and delivered count.
module tb_trace_addr_accumulator;
    localparam int    AW    = 31;
    localparam int    DEPTH = 8;
    localparam int    CW    = 32;
    localparam longint MASK = (64'd1 << AW) - 1;
    localparam longint CMAX = (64'd1 << CW) - 1;

    logic clk_41 = 1'b0;
    logic rst_41 = 1'b0;
    logic restart_41 = 1'b0;

    trace_addr_accumulator_if #(.AW(AW), .CW(CW)) bus();

    trace_addr_accumulator #(.AW(AW), .DEPTH(DEPTH), .CW(CW)) dut (
        .clk_41     (clk_41),
        .rst_41     (rst_41),
        .restart_41 (restart_41),
        .bus        (bus)
    );

    always #5 clk_41 = ~clk_41;

    longint q[$];
    longint got[$];
    longint m_acc, m_cnt;
    bit     seen, ended, done, started, took;
    int     n_chk = 0;
    int     n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic model_clear();
        q.delete();
        m_acc = 0; m_cnt = 0;
        seen = 0; ended = 0; done = 0;
    endtask

    task automatic chk_got(input string tag, input longint exp[$]);
        chk({tag, "_len"}, got.size(), exp.size());
        foreach (exp[i]) if (i < got.size()) chk(tag, got[i], exp[i]);
    endtask

    // One clock: drive inputs, compare outputs mid-cycle, advance the model to the next edge
    task automatic step(input bit v, input longint d, input bit l, input bit r, input bit rs);
        bit     mready;
        longint a;
        bus.delta_valid_41 = v;
        bus.delta_41       = d[AW-1:0];
        bus.delta_last_41  = l;
        bus.addr_ready_41  = r;
        restart_41         = rs;
        @(negedge clk_41);
        mready = started && !ended && (q.size() < DEPTH);
        chk("delta_ready", bus.delta_ready_41, mready);
        chk("addr_valid", bus.addr_valid_41, q.size() != 0);
        chk("addr", bus.addr_41, (q.size() != 0) ? q[0] : 0);
        chk("addr_count", bus.addr_count_41, m_cnt);
        chk("trace_done", bus.trace_done_41, done);
        took = 0;
        if (rs) begin
            model_clear();
        end else begin
            if (r && q.size() != 0) begin
                got.push_back(longint'(bus.addr_41));
                void'(q.pop_front());
                if (m_cnt < CMAX) m_cnt++;
            end
            if (v && mready) begin
                a = seen ? ((m_acc + d) & MASK) : (d & MASK);
                m_acc = a; seen = 1; took = 1;
                q.push_back(a);
                if (l) ended = 1;
            end
            if (ended && q.size() == 0) done = 1;
        end
        started = 1;
        @(posedge clk_41);
        #1;
    endtask

    task automatic hw_reset();
        rst_41 = 1'b0;
        #1;
        chk("rst_valid", bus.addr_valid_41, 0);
        chk("rst_addr", bus.addr_41, 0);
        chk("rst_count", bus.addr_count_41, 0);
        chk("rst_done", bus.trace_done_41, 0);
        chk("rst_ready", bus.delta_ready_41, 0);
        model_clear();
        started = 0;
        @(posedge clk_41);
        #1;
        rst_41 = 1'b1;
    endtask

    initial begin
        int     idx, guard;
        longint t4_d[10];
        bus.delta_valid_41 = 0;
        bus.delta_41 = '0;
        bus.delta_last_41 = 0;
        bus.addr_ready_41 = 0;
        model_clear();
        started = 0;
        #2;
        hw_reset();

        // T1: queue three entries, then reset mid-stream
        step(1, 10, 0, 0, 0);
        step(1, 10, 0, 0, 0);
        step(1, 20, 0, 0, 0);
        step(1, 30, 0, 0, 0);
        chk("t1_queued", bus.addr_valid_41, 1);
        hw_reset();
        step(0, 0, 0, 0, 0);
        got.delete();
        step(1, 500, 0, 1, 0);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 1, 0);
        chk_got("t1_addr", '{500});
        chk("t1_count", bus.addr_count_41, 1);

        // T2: accumulate with cache always ready
        step(0, 0, 0, 1, 1);
        got.delete();
        step(1, 100, 0, 1, 0);
        step(1, 4, 0, 1, 0);
        step(1, -8, 0, 1, 0);
        step(1, 1024, 1, 1, 0);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 1, 0);
        chk_got("t2_addr", '{100, 104, 96, 1120});
        chk("t2_count", bus.addr_count_41, 4);
        chk("t2_done", bus.trace_done_41, 1);

        // T3: modular wrap at 2^AW
        step(0, 0, 0, 1, 1);
        got.delete();
        step(1, 'h7FFFFFFF, 0, 1, 0);
        step(1, 1, 0, 1, 0);
        step(1, -1, 1, 1, 0);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 1, 0);
        chk_got("t3_addr", '{'h7FFFFFFF, 0, 'h7FFFFFFF});

        // T4: backpressure fills the FIFO, then drains in order
        step(0, 0, 0, 1, 1);
        got.delete();
        t4_d[0] = 1000;
        for (int i = 1; i < 10; i++) t4_d[i] = i;
        idx = 0;
        for (int i = 0; i < 12; i++) begin
            step(1, t4_d[idx], idx == 9, 0, 0);
            if (took) idx++;
        end
        chk("t4_accepted", idx, DEPTH);
        chk("t4_ready_low", bus.delta_ready_41, 0);
        guard = 0;
        while ((idx < 10 || q.size() != 0) && guard < 100) begin
            step(idx < 10, (idx < 10) ? t4_d[idx] : 0, idx == 9, 1, 0);
            if (took) idx++;
            guard++;
        end
        chk("t4_timeout", guard < 100, 1);
        chk_got("t4_addr", '{1000, 1001, 1003, 1006, 1010, 1015, 1021, 1028, 1036, 1045});

        // T5: trace end with random backpressure, then restart
        step(0, 0, 0, 1, 1);
        idx = 0;
        guard = 0;
        while (!done && guard < 60) begin
            step(idx < 3, (idx == 0) ? 7 : (idx == 1 ? 3 : 5), idx == 2, $urandom_range(1, 0), 0);
            if (took) idx++;
            guard++;
        end
        chk("t5_timeout", guard < 60, 1);
        step(0, 0, 0, 0, 0);
        chk("t5_done", bus.trace_done_41, 1);
        step(0, 0, 0, 0, 1);
        chk("t5_done_clr", bus.trace_done_41, 0);
        chk("t5_count_clr", bus.addr_count_41, 0);
        got.delete();
        step(1, 42, 0, 1, 0);
        step(0, 0, 0, 1, 0);
        chk_got("t5_abs", '{42});

        // T6: restart beats a same-cycle accept
        step(1, 9, 0, 1, 0);
        step(1, 77, 0, 0, 1);
        chk("t6_empty", bus.addr_valid_41, 0);
        got.delete();
        step(1, 55, 0, 1, 0);
        step(0, 0, 0, 1, 0);
        chk_got("t6_abs", '{55});

        // Randomized traces with occasional restarts
        for (int i = 0; i < 400; i++) begin
            longint d;
            d = ($urandom_range(3, 0) == 0) ? longint'($urandom) : longint'($urandom_range(200, 0)) - 100;
            step($urandom_range(3, 0) != 0, d, $urandom_range(15, 0) == 0,
                 $urandom_range(2, 0) != 0, done || ($urandom_range(60, 0) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
